// File: rtl/fifo_disp_pkg.sv
// ---------------------------------------------------------------------------
// fifo_disp_pkg
// Shared definitions for the FIFO lane dispatcher slice.
//   state_t : dispatcher FSM encoding (IDLE waits for a set, SEND emits beats)
//   clog2   : ceiling log2 with a floor of 1, used to size lane indices
// ---------------------------------------------------------------------------
package fifo_disp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // A single-lane configuration still needs a 1-bit index port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_lane_dispatcher_enc.sv
// ---------------------------------------------------------------------------
// lane_prio_enc
// Lowest-index-first priority encoder over the pending lane mask.
//   i_pend   : pending lane mask
//   o_idx    : index of the lowest set bit (0 when i_pend is zero)
//   o_onehot : one-hot of the lowest set bit (zero when i_pend is zero)
//   o_single : exactly one bit of i_pend is set
// ---------------------------------------------------------------------------
module lane_prio_enc
  import fifo_disp_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     i_pend,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot,
  output logic             o_single
);

  // Scanning downward lets the lowest set bit win the last assignment.
  // The two's-complement trick isolates that same bit for clearing,
  // and x & (x-1) strips it to test for a lone remaining bit.
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_pend[k]) o_idx = IDX_W'(k);
    end
    o_onehot = i_pend & (~i_pend + N'(1));
    o_single = (i_pend != '0) && ((i_pend & (i_pend - N'(1))) == '0);
  end

endmodule

// File: rtl/fifo_lane_dispatcher.sv
// ---------------------------------------------------------------------------
// fifo_lane_dispatcher
// Read-side scheduler for the 1:N set FIFO wrapper (read clock domain).
// Pops one wide set from the wrapper's FWFT port, captures it, and
// serializes its enabled lanes lowest index first onto a valid/ready
// lane channel. The next pop overlaps the final beat to avoid bubbles.
//   i_clk, i_rst      : read clock, synchronous active-high reset
//   i_flush           : abandon the current set, return to IDLE
//   i_lane_mask       : lane enables, sampled only when a set is captured
//   i_set_empty       : wrapper empty flag (low = held set valid)
//   i_set_data        : wrapper set data, lane k at [k*LANE_W +: LANE_W]
//   o_set_pop         : wrapper read enable, one cycle per captured set
//   o_lane_valid/i_lane_ready/o_lane_data/o_lane_idx/o_lane_last : beat channel
//   o_busy            : FSM is in SEND
//   o_set_count       : sets popped (wraps)
//   o_drop_count      : sets popped with an all-zero mask (wraps)
// ---------------------------------------------------------------------------
module fifo_lane_dispatcher
  import fifo_disp_pkg::*;
#(
  parameter int N      = 8,
  parameter int LANE_W = 8,
  parameter int IDX_W  = clog2(N),
  parameter int CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [N-1:0]          i_lane_mask,
  input  logic                  i_set_empty,
  input  logic [N*LANE_W-1:0]   i_set_data,
  output logic                  o_set_pop,
  output logic                  o_lane_valid,
  input  logic                  i_lane_ready,
  output logic [LANE_W-1:0]     o_lane_data,
  output logic [IDX_W-1:0]      o_lane_idx,
  output logic                  o_lane_last,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_set_count,
  output logic [CNT_W-1:0]      o_drop_count
);

  state_t                r_state, w_state_next;
  logic [N*LANE_W-1:0]   r_word, w_word_next;
  logic [N-1:0]          r_pend, w_pend_next;
  logic [CNT_W-1:0]      r_set_count, w_set_count_next;
  logic [CNT_W-1:0]      r_drop_count, w_drop_count_next;

  logic [IDX_W-1:0]      w_idx;
  logic [N-1:0]          w_onehot;
  logic                  w_single;
  logic                  w_send;
  logic                  w_hs;
  logic                  w_cap;

  lane_prio_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_pend   (r_pend),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_single (w_single)
  );

  // In SEND the pending mask is never zero, so w_single doubles as the
  // "current beat is last" flag. A capture happens from IDLE, or on the
  // handshake of the last beat so the next set streams without a gap.
  assign w_send = (r_state == ST_SEND);
  assign w_hs   = w_send && i_lane_ready;
  assign w_cap  = !i_set_empty && (!w_send || (w_hs && w_single))
                  && !i_flush && !i_rst;

  // Next-state logic: flush beats capture, capture beats a plain beat
  // retire. A zero mask is counted as a drop and never enters SEND.
  always_comb begin
    w_state_next      = r_state;
    w_word_next       = r_word;
    w_pend_next       = r_pend;
    w_set_count_next  = r_set_count;
    w_drop_count_next = r_drop_count;
    if (i_flush) begin
      w_state_next = ST_IDLE;
      w_pend_next  = '0;
    end else if (w_cap) begin
      w_word_next      = i_set_data;
      w_pend_next      = i_lane_mask;
      w_set_count_next = r_set_count + CNT_W'(1);
      if (i_lane_mask == '0) begin
        w_drop_count_next = r_drop_count + CNT_W'(1);
        w_state_next      = ST_IDLE;
      end else begin
        w_state_next = ST_SEND;
      end
    end else if (w_hs) begin
      w_pend_next = r_pend & ~w_onehot;
      if (w_single) w_state_next = ST_IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_pend       <= '0;
      r_set_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_word       <= w_word_next;
      r_pend       <= w_pend_next;
      r_set_count  <= w_set_count_next;
      r_drop_count <= w_drop_count_next;
    end
  end

  // Beat outputs derive from registered state only, so they are stable
  // under backpressure and all zero after reset (pend and word cleared).
  assign o_set_pop    = w_cap;
  assign o_lane_valid = w_send;
  assign o_busy       = w_send;
  assign o_lane_data  = r_word[w_idx*LANE_W +: LANE_W];
  assign o_lane_idx   = w_idx;
  assign o_lane_last  = w_single;
  assign o_set_count  = r_set_count;
  assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_fifo_lane_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_fifo_lane_dispatcher
// Scoreboard bench: sets pushed into an upstream FWFT queue expand into
// expected beats at push time; a negedge monitor tracks which set is in
// flight and compares pops, beats and counters against that expectation.
// ---------------------------------------------------------------------------
module tb_fifo_lane_dispatcher;

  localparam int N      = 4;
  localparam int LANE_W = 8;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [N*LANE_W-1:0] data;
    logic [N-1:0]        mask;
    int                  id;
  } set_t;

  typedef struct {
    logic [LANE_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
    int                id;
  } beat_t;

  logic                clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_flush = 1'b0;
  logic [N-1:0]        i_lane_mask = '0;
  logic                i_set_empty = 1'b1;
  logic [N*LANE_W-1:0] i_set_data = '0;
  logic                o_set_pop;
  logic                o_lane_valid;
  logic                i_lane_ready = 1'b0;
  logic [LANE_W-1:0]   o_lane_data;
  logic [IDX_W-1:0]    o_lane_idx;
  logic                o_lane_last;
  logic                o_busy;
  logic [CNT_W-1:0]    o_set_count;
  logic [CNT_W-1:0]    o_drop_count;

  set_t   upQ[$];
  beat_t  expQ[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     nextId = 0;
  int     lastPopped = -1;
  logic [CNT_W-1:0] modelSet = '0;
  logic [CNT_W-1:0] modelDrop = '0;
  bit     prevRst = 1'b0;

  fifo_lane_dispatcher #(
    .N      (N),
    .LANE_W (LANE_W),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_lane_mask  (i_lane_mask),
    .i_set_empty  (i_set_empty),
    .i_set_data   (i_set_data),
    .o_set_pop    (o_set_pop),
    .o_lane_valid (o_lane_valid),
    .i_lane_ready (i_lane_ready),
    .o_lane_data  (o_lane_data),
    .o_lane_idx   (o_lane_idx),
    .o_lane_last  (o_lane_last),
    .o_busy       (o_busy),
    .o_set_count  (o_set_count),
    .o_drop_count (o_drop_count)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, reports a miss.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A set enters the upstream queue; its enabled lanes become expected
  // beats in ascending lane order, the highest enabled lane marked last.
  task automatic pushSet(input logic [N*LANE_W-1:0] d, input logic [N-1:0] m);
    set_t  s;
    beat_t b;
    s.data = d;
    s.mask = m;
    s.id   = nextId;
    nextId++;
    upQ.push_back(s);
    for (int k = 0; k < N; k++) begin
      if (m[k]) begin
        b.data = d[k*LANE_W +: LANE_W];
        b.idx  = IDX_W'(k);
        b.last = ((m >> (k + 1)) == '0);
        b.id   = s.id;
        expQ.push_back(b);
      end
    end
  endtask

  // Drives one cycle of inputs shortly after the rising edge. The mask
  // always follows the head set, so it changes while earlier sets stream.
  task automatic applyStimulus(input bit rst, input bit flush, input bit ready,
                               input bit doPush, input logic [N*LANE_W-1:0] d,
                               input logic [N-1:0] m);
    @(posedge clk);
    #1;
    if (doPush) pushSet(d, m);
    i_rst        = rst;
    i_flush      = flush;
    i_lane_ready = (rst || flush) ? 1'b0 : ready;
    i_set_empty  = (upQ.size() == 0);
    if (upQ.size() > 0) begin
      i_set_data  = upQ[0].data;
      i_lane_mask = upQ[0].mask;
    end else begin
      i_set_data  = {$urandom};
      i_lane_mask = N'($urandom);
    end
  endtask

  // Monitor: compare mid-cycle, then advance the model by what the
  // coming rising edge will do.
  task automatic monitorCycle();
    bit   busy;
    bit   expPop;
    set_t h;
    busy   = (lastPopped >= 0) && (expQ.size() > 0) && (expQ[0].id == lastPopped);
    expPop = 1'b0;
    if (i_rst) begin
      checkOutput("pop_in_reset", 32'(o_set_pop), 32'd0);
    end else begin
      if (prevRst) begin
        checkOutput("rst_data", 32'(o_lane_data), 32'd0);
        checkOutput("rst_idx",  32'(o_lane_idx),  32'd0);
        checkOutput("rst_last", 32'(o_lane_last), 32'd0);
      end
      expPop = (upQ.size() > 0) && !i_flush && (!busy || (i_lane_ready && expQ[0].last));
      checkOutput("set_pop",    32'(o_set_pop),    32'(expPop));
      checkOutput("lane_valid", 32'(o_lane_valid), 32'(busy));
      checkOutput("busy",       32'(o_busy),       32'(busy));
      checkOutput("set_count",  32'(o_set_count),  32'(modelSet));
      checkOutput("drop_count", 32'(o_drop_count), 32'(modelDrop));
      if (busy) begin
        checkOutput("lane_data", 32'(o_lane_data), 32'(expQ[0].data));
        checkOutput("lane_idx",  32'(o_lane_idx),  32'(expQ[0].idx));
        checkOutput("lane_last", 32'(o_lane_last), 32'(expQ[0].last));
      end
    end
    if (i_rst || i_flush) begin
      while (busy && expQ.size() > 0 && expQ[0].id == lastPopped) void'(expQ.pop_front());
      lastPopped = -1;
      if (i_rst) begin
        modelSet  = '0;
        modelDrop = '0;
      end
    end else begin
      if (busy && i_lane_ready) void'(expQ.pop_front());
      if (expPop) begin
        h = upQ.pop_front();
        modelSet = modelSet + 1'b1;
        if (h.mask == '0) modelDrop = modelDrop + 1'b1;
        lastPopped = h.id;
      end
    end
    prevRst = i_rst;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitorCycle();
    end
  end

  initial begin
    $display("[TB] fifo_lane_dispatcher bench start");
    repeat (3) applyStimulus(1, 0, 0, 0, '0, '0);

    // Full mask, sparse mask, backpressure on the idx1 beat.
    applyStimulus(0, 0, 1, 1, 32'h44332211, 4'hF);
    repeat (6) applyStimulus(0, 0, 1, 0, '0, '0);
    applyStimulus(0, 0, 1, 1, 32'h44332211, 4'b1010);
    repeat (4) applyStimulus(0, 0, 1, 0, '0, '0);
    applyStimulus(0, 0, 1, 1, 32'h44332211, 4'hF);
    applyStimulus(0, 0, 1, 0, '0, '0);
    repeat (3) applyStimulus(0, 0, 0, 0, '0, '0);
    repeat (5) applyStimulus(0, 0, 1, 0, '0, '0);

    // Back-to-back streaming, then a zero-mask set.
    applyStimulus(0, 0, 1, 1, 32'h44332211, 4'hF);
    applyStimulus(0, 0, 1, 1, 32'h88776655, 4'hF);
    repeat (10) applyStimulus(0, 0, 1, 0, '0, '0);
    applyStimulus(0, 0, 1, 1, 32'hCAFEF00D, 4'h0);
    repeat (3) applyStimulus(0, 0, 1, 0, '0, '0);

    // Enough sets to wrap the narrow counters.
    for (int s = 0; s < 20; s++) begin
      applyStimulus(0, 0, 1, 1, {$urandom}, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
      repeat (4) applyStimulus(0, 0, 1, 0, '0, '0);
    end

    // Flush after the second beat.
    applyStimulus(0, 0, 1, 1, 32'h44332211, 4'hF);
    repeat (2) applyStimulus(0, 0, 1, 0, '0, '0);
    applyStimulus(0, 1, 0, 0, '0, '0);
    repeat (3) applyStimulus(0, 0, 1, 0, '0, '0);

    // Reset mid-set while a second set is held upstream.
    applyStimulus(0, 0, 1, 1, 32'hDDCCBBAA, 4'hF);
    applyStimulus(0, 0, 1, 1, 32'h44332211, 4'hF);
    applyStimulus(1, 0, 0, 0, '0, '0);
    repeat (8) applyStimulus(0, 0, 1, 0, '0, '0);

    // Randomized traffic with backpressure, flushes and resets.
    for (int c = 0; c < 2500; c++) begin
      bit rst, flush;
      rst   = ($urandom_range(0, 63) == 0);
      flush = !rst && ($urandom_range(0, 31) == 0);
      applyStimulus(rst, flush, $urandom_range(0, 3) != 0,
                    (upQ.size() < 4) && ($urandom_range(0, 2) == 0),
                    {$urandom}, ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom));
    end

    // Drain with a bounded cycle budget.
    for (int c = 0; c < 200 && (upQ.size() > 0 || expQ.size() > 0); c++)
      applyStimulus(0, 0, 1, 0, '0, '0);
    checkOutput("drain_left", 32'(upQ.size() + expQ.size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
